// File: rtl/hb_pkg.sv
// Shared types and sizing helpers for the heartbeat supervision blocks.
package hb_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } hb_state_t;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hb_sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
module hb_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic sync_p0;
  logic sync_p1;
  logic sync_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
      // ---- edge stage: sync_p2 is the previous synchronised level ----
      sync_p2 <= sync_p1;
      pulse   <= sync_p1 & ~sync_p2;
    end
  end

endmodule

// File: rtl/heartbeat_monitor.sv
// Heartbeat interval supervisor: classifies beat gaps and drives the ok line.
module heartbeat_monitor
  import hb_pkg::*;
#(
  parameter int MIN_GAP    = 4,
  parameter int MAX_GAP    = 10,
  parameter int MISS_LIMIT = 3,
  parameter int GOOD_LIMIT = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              hb_in,
  output logic                              ok,
  output logic                              early_err,
  output logic                              late_err,
  output logic [$clog2(MISS_LIMIT+1)-1:0]   miss_cnt
);

  localparam int GAP_W  = cnt_w(MAX_GAP + 1);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);
  localparam int GOOD_W = cnt_w(GOOD_LIMIT);

  localparam logic [GAP_W-1:0]  MIN_G  = GAP_W'(MIN_GAP);
  localparam logic [GAP_W-1:0]  MAX_G  = GAP_W'(MAX_GAP);
  localparam logic [GAP_W-1:0]  GAP_1  = GAP_W'(1);
  localparam logic [MISS_W-1:0] MISS_L = MISS_W'(MISS_LIMIT);
  localparam logic [GOOD_W-1:0] GOOD_L = GOOD_W'(GOOD_LIMIT);

  function automatic logic [MISS_W-1:0] sat_inc_miss(input logic [MISS_W-1:0] v);
    return (v >= MISS_L) ? MISS_L : v + MISS_W'(1);
  endfunction

  hb_state_t         state;
  logic [GAP_W-1:0]  gap;
  logic [GOOD_W-1:0] good_cnt;
  logic              hb_pulse;

  logic              is_good;
  logic              is_early;
  logic              is_late;
  logic              is_bad;
  logic [MISS_W-1:0] miss_next;
  logic [GOOD_W-1:0] good_next;

  hb_sync_edge u_sync_edge (
    .clk   (clk),
    .reset (reset),
    .d     (hb_in),
    .pulse (hb_pulse)
  );

  always_comb begin
    is_good   = hb_pulse && (gap >= MIN_G) && (gap <= MAX_G);
    is_early  = hb_pulse && (gap < MIN_G);
    is_late   = !hb_pulse && (gap == MAX_G);
    is_bad    = is_early || is_late;
    miss_next = sat_inc_miss(miss_cnt);
    good_next = good_cnt + GOOD_W'(1);
  end

  // ---- classification stage: counters, FSM and registered outputs ----
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state     <= INIT;
      gap       <= '0;
      miss_cnt  <= '0;
      good_cnt  <= '0;
      ok        <= 1'b1;
      early_err <= 1'b0;
      late_err  <= 1'b0;
    end else begin
      // A late event restarts the interval as if a beat had arrived.
      gap       <= (hb_pulse || is_late) ? GAP_1 : gap + GAP_1;
      early_err <= is_early && (state != INIT);
      late_err  <= is_late;
      case (state)
        INIT: begin
          if (hb_pulse) begin
            state <= RUN;
          end else if (is_late) begin
            miss_cnt <= miss_next;
            if (miss_next == MISS_L) begin
              state <= FAULT;
              ok    <= 1'b0;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (is_good) begin
            miss_cnt <= '0;
          end else if (is_bad) begin
            miss_cnt <= miss_next;
            if (miss_next == MISS_L) begin
              state <= FAULT;
              ok    <= 1'b0;
            end
          end
        end
        FAULT: begin
          if (is_good) begin
            if (good_next == GOOD_L) begin
              state    <= RUN;
              miss_cnt <= '0;
              good_cnt <= '0;
              ok       <= 1'b1;
            end else begin
              good_cnt <= good_next;
            end
          end else if (is_bad) begin
            good_cnt <= '0;
            miss_cnt <= miss_next;
          end
        end
        default: begin
          state <= INIT;
          ok    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Scenario bench for heartbeat_monitor with an error-event scoreboard.
module tb_heartbeat_monitor;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       hb_in;
  logic       ok;
  logic       early_err;
  logic       late_err;
  logic [1:0] miss_cnt;

  typedef struct packed {
    logic [31:0] cyc;
    logic        kind;  // 0 = early, 1 = late
    logic [1:0]  miss;
    logic        okv;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  cyc = 0;
  int  last_pulse = 0;
  int  n_cmp = 0;
  int  n_bad = 0;

  heartbeat_monitor #(
    .MIN_GAP(4), .MAX_GAP(10), .MISS_LIMIT(3), .GOOD_LIMIT(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .hb_in     (hb_in),
    .ok        (ok),
    .early_err (early_err),
    .late_err  (late_err),
    .miss_cnt  (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk_ev(input int c, input int k, input int m, input logic o);
    ev_t r;
    r.cyc  = c;
    r.kind = k[0];
    r.miss = m[1:0];
    r.okv  = o;
    return r;
  endfunction

  // Observed error pulses, stamped with the cycle they are visible in.
  always @(negedge clk) begin
    if (early_err || late_err)
      obs_q.push_back(mk_ev(cyc, late_err ? 1 : 0, int'(miss_cnt), ok));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // A rise at the negedge of cycle K reaches the pulse register in cycle K+3.
  task automatic beat(input int after, input int hold);
    last_pulse = cyc + 3;
    hb_in = 1'b1;
    repeat (hold) @(negedge clk);
    hb_in = 1'b0;
    repeat (after - hold) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b1;
    hb_in  = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    obs_q.delete();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b1;
    hb_in  = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL reset_ok: got %b want 1", ok); end
    n_cmp++; if (early_err !== 1'b0) begin n_bad++; $display("FAIL reset_early: got %b want 0", early_err); end
    n_cmp++; if (late_err !== 1'b0) begin n_bad++; $display("FAIL reset_late: got %b want 0", late_err); end
    n_cmp++; if (miss_cnt !== 2'd0) begin n_bad++; $display("FAIL reset_miss: got %0d want 0", miss_cnt); end
  endtask

  task automatic test_steady();
    do_reset();
    for (int i = 0; i < 10; i++) beat(8, 1);
    beat(8, 5);
    beat(8, 1);
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL steady_events: got %0d error pulses want 0", obs_q.size()); end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL steady_ok: got %b want 1", ok); end
    n_cmp++; if (miss_cnt !== 2'd0) begin n_bad++; $display("FAIL steady_miss: got %0d want 0", miss_cnt); end
  endtask

  task automatic test_late();
    ev_t e, o;
    int p;
    do_reset();
    repeat (3) beat(8, 1);
    p = last_pulse;
    exp_q.push_back(mk_ev(p + 11, 1, 1, 1'b1));
    exp_q.push_back(mk_ev(p + 21, 1, 2, 1'b1));
    exp_q.push_back(mk_ev(p + 31, 1, 3, 1'b0));
    wait_until(p + 35);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL late_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL late_event: got cyc=%0d kind=%0d miss=%0d ok=%b want cyc=%0d kind=%0d miss=%0d ok=%b",
                 o.cyc, o.kind, o.miss, o.okv, e.cyc, e.kind, e.miss, e.okv);
      end
    end
    n_cmp++; if (ok !== 1'b0) begin n_bad++; $display("FAIL late_ok: got %b want 0", ok); end
    n_cmp++; if (miss_cnt !== 2'd3) begin n_bad++; $display("FAIL late_miss: got %0d want 3", miss_cnt); end
  endtask

  task automatic test_early();
    ev_t e, o;
    int q[4];
    do_reset();
    beat(8, 1);
    beat(8, 1);
    for (int i = 0; i < 4; i++) begin
      beat(3, 1);
      q[i] = last_pulse;
    end
    exp_q.push_back(mk_ev(q[1] + 1, 0, 1, 1'b1));
    exp_q.push_back(mk_ev(q[2] + 1, 0, 2, 1'b1));
    exp_q.push_back(mk_ev(q[3] + 1, 0, 3, 1'b0));
    wait_until(q[3] + 2);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL early_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL early_event: got cyc=%0d kind=%0d miss=%0d ok=%b want cyc=%0d kind=%0d miss=%0d ok=%b",
                 o.cyc, o.kind, o.miss, o.okv, e.cyc, e.kind, e.miss, e.okv);
      end
    end
    n_cmp++; if (ok !== 1'b0) begin n_bad++; $display("FAIL early_ok: got %b want 0", ok); end
    n_cmp++; if (miss_cnt !== 2'd3) begin n_bad++; $display("FAIL early_miss: got %0d want 3", miss_cnt); end
  endtask

  task automatic test_boundary();
    ev_t e, o;
    int p5, p6;
    do_reset();
    beat(8, 1);
    beat(4, 1);
    beat(10, 1);
    beat(2, 1);
    beat(6, 1);
    p5 = last_pulse;
    exp_q.push_back(mk_ev(p5 + 1, 0, 1, 1'b1));
    n_cmp++; if (miss_cnt !== 2'd1) begin n_bad++; $display("FAIL bound_miss_after_bad: got %0d want 1", miss_cnt); end
    beat(4, 1);
    p6 = last_pulse;
    wait_until(p6 + 2);
    n_cmp++; if (miss_cnt !== 2'd0) begin n_bad++; $display("FAIL bound_miss_cleared: got %0d want 0", miss_cnt); end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL bound_ok: got %b want 1", ok); end
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL bound_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL bound_event: got cyc=%0d kind=%0d miss=%0d ok=%b want cyc=%0d kind=%0d miss=%0d ok=%b",
                 o.cyc, o.kind, o.miss, o.okv, e.cyc, e.kind, e.miss, e.okv);
      end
    end
  endtask

  task automatic test_fault_recovery();
    ev_t e, o;
    int p3, p4, p5, p7, p9;
    do_reset();
    beat(8, 1);
    beat(3, 1);
    beat(3, 1); p3 = last_pulse;
    beat(3, 1); p4 = last_pulse;
    beat(6, 1); p5 = last_pulse;
    beat(2, 1);
    beat(6, 1); p7 = last_pulse;
    beat(6, 1);
    beat(3, 1); p9 = last_pulse;
    exp_q.push_back(mk_ev(p3 + 1, 0, 1, 1'b1));
    exp_q.push_back(mk_ev(p4 + 1, 0, 2, 1'b1));
    exp_q.push_back(mk_ev(p5 + 1, 0, 3, 1'b0));
    exp_q.push_back(mk_ev(p7 + 1, 0, 3, 1'b0));
    wait_until(p9);
    n_cmp++; if (ok !== 1'b0) begin n_bad++; $display("FAIL recov_ok_before: got %b want 0", ok); end
    @(negedge clk);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL recov_ok_after: got %b want 1", ok); end
    n_cmp++; if (miss_cnt !== 2'd0) begin n_bad++; $display("FAIL recov_miss: got %0d want 0", miss_cnt); end
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL recov_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL recov_event: got cyc=%0d kind=%0d miss=%0d ok=%b want cyc=%0d kind=%0d miss=%0d ok=%b",
                 o.cyc, o.kind, o.miss, o.okv, e.cyc, e.kind, e.miss, e.okv);
      end
    end
  endtask

  task automatic test_bypass();
    int p;
    do_reset();
    beat(8, 1);
    repeat (3) beat(3, 1);
    beat(3, 1);
    p = last_pulse;
    wait_until(p + 2);
    n_cmp++; if (ok !== 1'b0) begin n_bad++; $display("FAIL bypass_in_fault: got %b want 0", ok); end
    enable = 1'b0;
    @(negedge clk);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL bypass_ok: got %b want 1", ok); end
    n_cmp++; if (miss_cnt !== 2'd0) begin n_bad++; $display("FAIL bypass_miss: got %0d want 0", miss_cnt); end
    obs_q.delete();
    repeat (30) @(negedge clk);
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL bypass_silence: got %0d error pulses want 0", obs_q.size()); end
    // First beat after re-enable comes at a short gap; INIT must not judge it.
    enable = 1'b1;
    beat(8, 1);
    beat(8, 1);
    beat(8, 1);
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL bypass_restart_events: got %0d error pulses want 0", obs_q.size()); end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL bypass_restart_ok: got %b want 1", ok); end
    repeat (3) beat(3, 1);
    beat(3, 1);
    p = last_pulse;
    wait_until(p + 2);
    n_cmp++; if (ok !== 1'b0) begin n_bad++; $display("FAIL rst_in_fault: got %b want 0", ok); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rst_ok: got %b want 1", ok); end
    n_cmp++; if (miss_cnt !== 2'd0) begin n_bad++; $display("FAIL rst_miss: got %0d want 0", miss_cnt); end
    reset = 1'b0;
    obs_q.delete();
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    hb_in  = 1'b0;
    @(negedge clk);
    test_reset();
    test_steady();
    test_late();
    test_early();
    test_boundary();
    test_fault_recovery();
    test_bypass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
